// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector: stalls PC and IF/ID and bubbles ID/EX when a load's rt feeds the next instruction.
// Latency: hazard outputs are combinational (0 cycles); stall_q and stall_count are updated at the next edge.
// No backpressure; define HDU_PERF_CNT_EN to build the saturating stall counter, otherwise stall_count is 0.
module hazard_detection_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] idexrt,
  input  logic [REG_AW-1:0] ifidrs,
  input  logic [REG_AW-1:0] ifidrt,
  input  logic              idexmemrd,
  input  logic              cnt_clr,
  output logic              pcen,
  output logic              ifidwen,
  output logic              ctrlsig,
  output logic              stall_q,
  output logic [CNT_W-1:0]  stall_count
);

  logic hazard;

  // Register 0 is hardwired to zero, so a load into it never creates a dependency.
  assign hazard = idexmemrd & (idexrt != '0) &
                  ((idexrt == ifidrs) | (idexrt == ifidrt));

  always_comb begin
    pcen    = ~hazard;
    ifidwen = ~hazard;
    ctrlsig = hazard;
    if (rst) begin
      pcen    = 1'b0;
      ifidwen = 1'b0;
      ctrlsig = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 1'b0;
    end else begin
      stall_q <= hazard;
    end
  end

`ifdef HDU_PERF_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Clear wins over a same-cycle hazard; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (hazard && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign stall_count = cnt;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign stall_count    = '0;
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: a default-width instance plus a CNT_W=2 instance for saturation.
module tb_hazard_detection_unit;

`ifdef HDU_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  idexrt, ifidrs, ifidrt;
  logic        idexmemrd, cnt_clr;
  logic        pcen, ifidwen, ctrlsig, stall_q;
  logic [31:0] stall_count;
  logic        pcen2, ifidwen2, ctrlsig2, stall_q2;
  logic [1:0]  stall_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.REG_AW(5), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .idexrt(idexrt), .ifidrs(ifidrs), .ifidrt(ifidrt),
    .idexmemrd(idexmemrd), .cnt_clr(cnt_clr), .pcen(pcen), .ifidwen(ifidwen),
    .ctrlsig(ctrlsig), .stall_q(stall_q), .stall_count(stall_count)
  );

  hazard_detection_unit #(.REG_AW(5), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .idexrt(idexrt), .ifidrs(ifidrs), .ifidrt(ifidrt),
    .idexmemrd(idexmemrd), .cnt_clr(cnt_clr), .pcen(pcen2), .ifidwen(ifidwen2),
    .ctrlsig(ctrlsig2), .stall_q(stall_q2), .stall_count(stall_count2)
  );

  task automatic drive(input logic m, input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt);
    idexmemrd = m;
    idexrt    = xrt;
    ifidrs    = rs;
    ifidrt    = rt;
  endtask

  task automatic test_reset();
    logic [31:0] exp_cnt;
    rst = 1'b1;
    cnt_clr = 1'b0;
    drive(1'b1, 5'd1, 5'd1, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    total++; if (pcen !== 1'b0) begin bad++; $display("FAIL reset_pcen got=%b exp=0", pcen); end
    total++; if (ifidwen !== 1'b0) begin bad++; $display("FAIL reset_ifidwen got=%b exp=0", ifidwen); end
    total++; if (ctrlsig !== 1'b1) begin bad++; $display("FAIL reset_ctrlsig got=%b exp=1", ctrlsig); end
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL reset_stall_q got=%b exp=0", stall_q); end
    exp_cnt = 32'd0;
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL reset_count got=%0d exp=0", stall_count); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0);
    rst = 1'b0;
    #1;
    total++; if (pcen !== 1'b1) begin bad++; $display("FAIL release_pcen got=%b exp=1", pcen); end
    total++; if (ifidwen !== 1'b1) begin bad++; $display("FAIL release_ifidwen got=%b exp=1", ifidwen); end
    total++; if (ctrlsig !== 1'b0) begin bad++; $display("FAIL release_ctrlsig got=%b exp=0", ctrlsig); end
  endtask

  task automatic test_rt_match();
    logic [31:0] exp_cnt;
    @(negedge clk);
    drive(1'b1, 5'd1, 5'd0, 5'd1);
    #1;
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b001) begin bad++; $display("FAIL rt_match_comb got=%b exp=001", {pcen, ifidwen, ctrlsig}); end
    @(posedge clk); #1;
    exp_cnt = CNT_EN ? 32'd1 : 32'd0;
    total++; if (stall_q !== 1'b1) begin bad++; $display("FAIL rt_match_stall_q got=%b exp=1", stall_q); end
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL rt_match_count got=%0d exp=%0d", stall_count, exp_cnt); end
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL rt_match_after_q got=%b exp=0", stall_q); end
  endtask

  task automatic test_rs_match();
    logic [31:0] exp_cnt;
    @(negedge clk);
    drive(1'b1, 5'd2, 5'd2, 5'd1);
    #1;
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b001) begin bad++; $display("FAIL rs_match_comb got=%b exp=001", {pcen, ifidwen, ctrlsig}); end
    drive(1'b1, 5'd2, 5'd3, 5'd1);
    #1;
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b110) begin bad++; $display("FAIL rs_nomatch_comb got=%b exp=110", {pcen, ifidwen, ctrlsig}); end
    @(posedge clk); #1;
    exp_cnt = CNT_EN ? 32'd1 : 32'd0;
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL rs_nomatch_q got=%b exp=0", stall_q); end
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL rs_nomatch_count got=%0d exp=%0d", stall_count, exp_cnt); end
  endtask

  task automatic test_no_hazard();
    logic [31:0] exp_cnt;
    @(negedge clk);
    drive(1'b0, 5'd5, 5'd5, 5'd0);
    #1;
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b110) begin bad++; $display("FAIL nonload_comb got=%b exp=110", {pcen, ifidwen, ctrlsig}); end
    drive(1'b1, 5'd0, 5'd0, 5'd0);
    #1;
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b110) begin bad++; $display("FAIL r0_load_comb got=%b exp=110", {pcen, ifidwen, ctrlsig}); end
    @(posedge clk); #1;
    exp_cnt = CNT_EN ? 32'd1 : 32'd0;
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL r0_load_q got=%b exp=0", stall_q); end
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL r0_load_count got=%0d exp=%0d", stall_count, exp_cnt); end
  endtask

  task automatic test_counter();
    logic [31:0] exp_cnt;
    logic [1:0]  exp_cnt2;
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL clr_idle_count got=%0d exp=0", stall_count); end
    @(negedge clk);
    cnt_clr = 1'b0;
    drive(1'b1, 5'd7, 5'd7, 5'd7);  // both sources match: one stall per cycle
    repeat (3) @(posedge clk);
    #1;
    exp_cnt  = CNT_EN ? 32'd3 : 32'd0;
    exp_cnt2 = CNT_EN ? 2'd3 : 2'd0;
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL hold3_count got=%0d exp=%0d", stall_count, exp_cnt); end
    total++; if (stall_q !== 1'b1) begin bad++; $display("FAIL hold3_q got=%b exp=1", stall_q); end
    total++; if (stall_count2 !== exp_cnt2) begin bad++; $display("FAIL hold3_count_w2 got=%0d exp=%0d", stall_count2, exp_cnt2); end
    repeat (2) @(posedge clk);
    #1;
    exp_cnt  = CNT_EN ? 32'd5 : 32'd0;
    exp_cnt2 = CNT_EN ? 2'd3 : 2'd0;
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL hold5_count got=%0d exp=%0d", stall_count, exp_cnt); end
    total++; if (stall_count2 !== exp_cnt2) begin bad++; $display("FAIL sat_count_w2 got=%0d exp=%0d", stall_count2, exp_cnt2); end
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL clr_hazard_count got=%0d exp=0", stall_count); end
    total++; if (stall_count2 !== 2'd0) begin bad++; $display("FAIL clr_hazard_count_w2 got=%0d exp=0", stall_count2); end
    total++; if (stall_q !== 1'b1) begin bad++; $display("FAIL clr_hazard_q got=%b exp=1", stall_q); end
    @(negedge clk);
    cnt_clr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_cnt;
    repeat (2) @(posedge clk);
    #1;
    exp_cnt = CNT_EN ? 32'd2 : 32'd0;
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL pre_areset_count got=%0d exp=%0d", stall_count, exp_cnt); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL areset_count got=%0d exp=0", stall_count); end
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL areset_q got=%b exp=0", stall_q); end
    total++; if ({pcen, ifidwen, ctrlsig} !== 3'b001) begin bad++; $display("FAIL areset_comb got=%b exp=001", {pcen, ifidwen, ctrlsig}); end
    @(posedge clk); #1;
    total++; if (stall_q !== 1'b0) begin bad++; $display("FAIL areset_hold_q got=%b exp=0", stall_q); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5'd4, 5'd9, 5'd4);
    @(posedge clk); #1;
    exp_cnt = CNT_EN ? 32'd1 : 32'd0;
    total++; if (stall_count !== exp_cnt) begin bad++; $display("FAIL post_areset_count got=%0d exp=%0d", stall_count, exp_cnt); end
    total++; if (stall_q !== 1'b1) begin bad++; $display("FAIL post_areset_q got=%b exp=1", stall_q); end
  endtask

  initial begin
    test_reset();
    test_rt_match();
    test_rs_match();
    test_no_hazard();
    test_counter();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Load-use hazard detector for the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX pipeline registers.
- When the ID/EX instruction is a load whose destination (rt) matches either source register of the IF/ID instruction, it stalls PC and IF/ID for one cycle and injects a bubble into ID/EX.
- Also keeps a registered stall flag and a saturating stall-event counter for debug and performance.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, stall-counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset; asynchronous and active-high.
- idexrt  input  REG_AW  rt (load destination) of the instruction in ID/EX.
- ifidrs  input  REG_AW  rs of the instruction in IF/ID.
- ifidrt  input  REG_AW  rt of the instruction in IF/ID.
- idexmemrd  input  1  ID/EX instruction reads memory (load).
- cnt_clr  input  1  synchronous clear of stall_count.
- pcen  output  1  PC write enable (1 = advance).
- ifidwen  output  1  IF/ID write enable (1 = load).
- ctrlsig  output  1  bubble select; 1 = mux zeros into the ID/EX control fields.
- stall_q  output  1  registered: a stall was asserted in the previous cycle.
- stall_count  output  CNT_W  number of stall cycles since reset or clear.

Behaviour:
- Combinational hazard term: hazard = idexmemrd & (idexrt != 0) & ((idexrt == ifidrs) | (idexrt == ifidrt)).
- A load to register 0 never causes a stall.
- Combinational outputs, zero latency:
  - pcen = ~hazard.
  - ifidwen = ~hazard.
  - ctrlsig = hazard.
- While rst = 1, the combinational outputs are forced to the safe hold state: pcen = 0, ifidwen = 0, ctrlsig = 1.
- Registered outputs during rst = 1 (asynchronous): stall_q = 0, stall_count = 0.
- stall_q <= hazard on each rising clk when not in reset.
- stall_count, on each rising clk when not in reset:
  - cnt_clr = 1: load 0. Clear has priority over increment in the same cycle; that cycle's hazard is not counted.
  - else if hazard: increment by 1, saturating at all-ones.
  - else: hold.
- Any X/unknown on idexmemrd is not specified. Inputs are sampled as given; the block adds no input registering.
- Deassertion of rst takes effect immediately for the combinational outputs. Registers leave reset at the next clk edge.
- A hazard present for consecutive cycles (input held) keeps the stall asserted every cycle and counts every cycle.
- Both rs and rt matching the load destination is a single stall, counted once.

Optional Feature:
- Macro HDU_PERF_CNT_EN.
- Defined: stall_count is implemented as described above.
- Not defined:
  - stall_count is tied to 0 and no counter flops are synthesised.
  - cnt_clr is ignored.
  - stall_q and all hazard outputs are unchanged.

Test Plan:
- Reset: rst = 1 with any inputs -> pcen = 0, ifidwen = 0, ctrlsig = 1, stall_q = 0, stall_count = 0. Release rst with idexmemrd = 0 -> pcen = 1, ifidwen = 1, ctrlsig = 0.
- rt match: idexmemrd = 1, idexrt = 1, ifidrs = 0, ifidrt = 1 -> pcen = 0, ifidwen = 0, ctrlsig = 1 immediately; stall_q = 1 and stall_count = 1 after the next edge.
- rs match: idexmemrd = 1, idexrt = 2, ifidrs = 2, ifidrt = 1 -> stall asserted. Then set idexrt = 2, ifidrs = 3, ifidrt = 1 -> no stall, pcen = 1, ctrlsig = 0.
- Non-load and zero register:
  - idexmemrd = 0, idexrt = ifidrs = 5 -> no stall.
  - idexmemrd = 1, idexrt = 0, ifidrs = 0 -> no stall, counter unchanged.
- Counter:
  - Hold the hazard for 3 cycles -> stall_count = 3.
  - Assert cnt_clr together with a hazard -> stall_count = 0 next cycle.
  - With CNT_W = 2, hold the hazard for 5 cycles -> stall_count saturates at 3.
- Async reset mid-stall: hazard held, stall_count = 2; assert rst between edges -> stall_count = 0 and stall_q = 0 immediately, without a clock edge.
